mem_handshake_unit: RTL and testbench
=====================================

MEM_HANDSHAKE_UNIT -- requirements
Module: mem_handshake_unit

Interface
REQ-001 Parameter: WAIT_STATES, default 0, idle cycles inserted before each byte transfer (range 0..7).
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MOV  input  1  memory-operation-valid request from the control unit.
REQ-005 RW  input  1  access direction: 1 = read, 0 = write.
REQ-006 m  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 addr  input  8  byte address of the first byte (MAR value).
REQ-008 data_in  input  32  write data (MDR value); write bytes are right-justified.
REQ-009 data_out  output  32  read result; zero-extended for byte and halfword accesses.
REQ-010 MOC  output  1  memory-operation-complete.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  misaligned-access flag; see Configuration.

Function
REQ-013 The unit SHALL contain a 256x8 storage array, addressable by the bench, big-endian: the byte at addr is the most significant byte.
REQ-014 The FSM SHALL have states IDLE, WAIT, XFER and DONE.
REQ-015 IDLE with MOV=1 SHALL latch addr, m, RW and data_in, set the byte count N (1/2/4), and go to WAIT if WAIT_STATES>0, else to XFER.
REQ-016 WAIT SHALL count WAIT_STATES cycles and then go to XFER.
REQ-017 Each XFER cycle SHALL move one byte at address (latched addr + i) mod 256, for i = 0..N-1; after the last byte the FSM SHALL go to DONE, otherwise to WAIT or XFER.
REQ-018 Write bytes: a halfword writes data_in[15:8] to addr and [7:0] to addr+1; a word writes [31:24] first and [7:0] last.
REQ-019 Read bytes SHALL be assembled in a shift register; data_out SHALL update only on entry to DONE and SHALL hold its value otherwise.
REQ-020 MOC SHALL be 1 only in DONE; DONE SHALL go to IDLE on the first edge that samples MOV=0.
REQ-021 While MOV stays high in DONE, MOC SHALL stay 1 and no new access SHALL start.
REQ-022 MOV deasserted during WAIT/XFER SHALL be ignored; the transfer SHALL complete.
REQ-023 Latency: MOC SHALL rise N*(1+WAIT_STATES)+1 edges after the accepting edge (byte 2, halfword 3, word 5 at WAIT_STATES=0).
REQ-024 Address arithmetic SHALL wrap modulo 256.
REQ-025 err SHALL be set on entry to DONE, held through DONE, and cleared on the next accept or reset.

Reset
REQ-026 reset SHALL force IDLE, MOC=0, busy=0, err=0, data_out=0 and clear the wait/byte counters.
REQ-027 reset SHALL NOT clear the storage array; bytes already written by an interrupted access SHALL remain written.
REQ-028 reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-029 With MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL go directly from IDLE to DONE with err=1, no storage write and data_out unchanged; MOC SHALL rise 1 edge after accept.
  - misaligned halfword: addr[0]=1
  - misaligned word: addr[1:0]!=0
REQ-030 Without MEM_ALIGN_CHECK_EN, err SHALL be constant 0 and misaligned accesses SHALL proceed with wrap-around.

Verification (WAIT_STATES=0 unless stated)
REQ-031 Word read:
  - stimulus: preload bytes 0..3 = E2,8F,10,04; word read at addr 0
  - response: data_out=32'hE28F1004; MOC rises on the 5th edge after accept
REQ-032 Byte access:
  - stimulus: byte write 8'hAB to addr 9, then byte read at addr 9
  - response: data_out=32'h000000AB; bytes 8 and 10 unchanged
REQ-033 Wrap-around (check disabled):
  - stimulus: preload 253..255,0 = 11,22,33,44; word read at addr 253
  - response: data_out=32'h11223344; err=0
REQ-034 Alignment check (MEM_ALIGN_CHECK_EN):
  - stimulus: word write at addr 2
  - response: err=1; MOC rises 1 edge after accept; bytes 2..5 unchanged
REQ-035 Reset mid-access:
  - stimulus: reset asserted after 2 XFER cycles of a word write at addr 16
  - response: MOC=0 and busy=0 next edge; bytes 16,17 written; bytes 18,19 unchanged
REQ-036 Handshake and wait states:
  - stimulus: MOV held high for 3 cycles after MOC, then dropped
  - response: MOC stays high for those 3 cycles; MOC falls on the edge sampling MOV=0; no second access occurs
  - with WAIT_STATES=2, a word read's MOC rises on edge 13 after accept

Source files
------------

// File: rtl/mem_handshake_unit.sv
// mem_handshake_unit: byte-serial 256x8 big-endian memory behind a MOV/MOC handshake with optional wait states.
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with err.
module mem_handshake_unit #(
   parameter int WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        MOV,
   input  logic        RW,
   input  logic [1:0]  m,
   input  logic [7:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        MOC,
   output logic        busy,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
   state_t      r_state;
   logic [7:0]  r_mem [256];
   logic [7:0]  r_addr;
   logic        r_rw;
   logic [1:0]  r_last;
   logic [1:0]  r_idx;
   logic [2:0]  r_wcnt;
   logic [31:0] r_sh;
   logic [31:0] r_dout;
   logic        r_moc;
   logic        r_busy;
   logic        r_err;
   logic [7:0]  w_rbyte;
   logic [1:0]  w_last;
   logic [31:0] w_wdata;
   logic        w_mis;
   assign w_rbyte = r_mem[r_addr];
   assign w_last  = m == 2'b00 ? 2'd0 : m == 2'b01 ? 2'd1 : 2'd3;
   assign w_wdata = m == 2'b00 ? {data_in[7:0], 24'd0} : m == 2'b01 ? {data_in[15:0], 16'd0} : data_in;
`ifdef MEM_ALIGN_CHECK_EN
   assign w_mis = (m == 2'b01 && addr[0]) || (m[1] && addr[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif
   assign data_out = r_dout;
   assign MOC      = r_moc;
   assign busy     = r_busy;
   assign err      = r_err;
   // Handshake FSM: one shift register carries write bytes out (MSB first) and read bytes in
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= IDLE;
         r_moc   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_dout  <= 32'd0;
         r_wcnt  <= 3'd0;
         r_idx   <= 2'd0;
      end else begin
         case (r_state)
            IDLE: if (MOV) begin
               r_addr  <= addr;
               r_rw    <= RW;
               r_last  <= w_last;
               r_idx   <= 2'd0;
               r_wcnt  <= 3'd0;
               r_sh    <= RW ? 32'd0 : w_wdata;
               r_err   <= w_mis;
               r_moc   <= w_mis;
               r_busy  <= 1'b1;
               r_state <= w_mis ? DONE : WAIT_STATES > 0 ? WAIT : XFER;
            end
            WAIT: begin
               r_wcnt  <= r_wcnt == 3'(WAIT_STATES - 1) ? 3'd0 : r_wcnt + 3'd1;
               r_state <= r_wcnt == 3'(WAIT_STATES - 1) ? XFER : WAIT;
            end
            XFER: begin
               r_sh   <= {r_sh[23:0], w_rbyte};
               r_addr <= r_addr + 8'd1;
               r_idx  <= r_idx + 2'd1;
               if (r_idx == r_last) begin
                  r_state <= DONE;
                  r_moc   <= 1'b1;
                  if (r_rw) r_dout <= {r_sh[23:0], w_rbyte};
               end else begin
                  r_state <= WAIT_STATES > 0 ? WAIT : XFER;
               end
            end
            DONE: if (!MOV) begin
               r_state <= IDLE;
               r_moc   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   // Storage write port; kept out of the reset branch so reset never clears memory
   always_ff @(posedge CLK) begin
      if (!reset && r_state == XFER && !r_rw) r_mem[r_addr] <= r_sh[31:24];
   end
endmodule

// File: tb/tb_mem_handshake_unit.sv
// tb_mem_handshake_unit: directed and randomized checks of mem_handshake_unit against a byte-array model.
module tb_mem_handshake_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mov0 = 1'b0;
   logic        mov2 = 1'b0;
   logic        rw = 1'b0;
   logic [1:0]  m = 2'b00;
   logic [7:0]  addr = 8'd0;
   logic [31:0] din = 32'd0;
   logic [31:0] dout0, dout2;
   logic        moc0, moc2, busy0, busy2, err0, err2;
   int          vectors = 0;
   int          miscompares = 0;
   bit [7:0]    model [2][256];
   bit          known [2][256];
   bit [31:0]   edout [2];
   bit          eerr [2];
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   mem_handshake_unit #(.WAIT_STATES(0)) dut (
      .CLK(clk), .reset(reset), .MOV(mov0), .RW(rw), .m(m), .addr(addr), .data_in(din),
      .data_out(dout0), .MOC(moc0), .busy(busy0), .err(err0));
   mem_handshake_unit #(.WAIT_STATES(2)) dut2 (
      .CLK(clk), .reset(reset), .MOV(mov2), .RW(rw), .m(m), .addr(addr), .data_in(din),
      .data_out(dout2), .MOC(moc2), .busy(busy2), .err(err2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] mread(input int s, input bit [7:0] a, input int n);
      bit [31:0] v = 32'd0;
      for (int i = 0; i < n; i++) v = {v[23:0], model[s][8'(a + i)]};
      return v;
   endfunction

   task automatic mem_check(input int s, input string tag);
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (known[s][i] && (s == 1 ? dut2.r_mem[i] : dut.r_mem[i]) != model[s][i]) bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   task automatic set_mov(input int s, input logic v);
      if (s == 1) mov2 = v; else mov0 = v;
   endtask

   task automatic access(input int s, input bit r, input bit [1:0] mm, input bit [7:0] a,
                         input bit [31:0] d, input int hold, input string tag);
      int n, lat, edges;
      bit mis;
      bit [31:0] prev;
      n = mm == 2'd0 ? 1 : mm == 2'd1 ? 2 : 4;
      mis = ALIGN && ((mm == 2'd1 && a[0]) || (mm[1] && a[1:0] != 2'd0));
      lat = mis ? 1 : n * (1 + (s == 1 ? 2 : 0)) + 1;
      prev = edout[s];
      eerr[s] = mis;
      if (!mis) begin
         if (r) edout[s] = mread(s, a, n);
         else for (int i = 0; i < n; i++) begin
            model[s][8'(a + i)] = d[8 * (n - 1 - i) +: 8];
            known[s][8'(a + i)] = 1'b1;
         end
      end
      @(negedge clk);
      rw = r; m = mm; addr = a; din = d;
      set_mov(s, 1'b1);
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
         if (!(s == 1 ? moc2 : moc0) && edges < 40) begin
            chk({tag, " busy"}, 32'(s == 1 ? busy2 : busy0), 32'd1);
            chk({tag, " dout_hold"}, s == 1 ? dout2 : dout0, prev);
            rw = 1'($urandom); m = 2'($urandom); addr = 8'($urandom); din = $urandom;
            set_mov(s, 1'($urandom));
         end
      end while (!(s == 1 ? moc2 : moc0) && edges < 40);
      chk({tag, " latency"}, 32'(edges), 32'(lat));
      chk({tag, " data_out"}, s == 1 ? dout2 : dout0, edout[s]);
      chk({tag, " err"}, 32'(s == 1 ? err2 : err0), 32'(eerr[s]));
      chk({tag, " busy_done"}, 32'(s == 1 ? busy2 : busy0), 32'd1);
      set_mov(s, hold > 0);
      for (int h = 0; h < hold; h++) begin
         rw = 1'($urandom); m = 2'($urandom); addr = 8'($urandom); din = $urandom;
         @(negedge clk);
         chk({tag, " hold_moc"}, 32'(s == 1 ? moc2 : moc0), 32'd1);
         chk({tag, " hold_dout"}, s == 1 ? dout2 : dout0, edout[s]);
      end
      set_mov(s, 1'b0);
      @(negedge clk);
      chk({tag, " moc_fall"}, 32'(s == 1 ? moc2 : moc0), 32'd0);
      chk({tag, " idle_busy"}, 32'(s == 1 ? busy2 : busy0), 32'd0);
      chk({tag, " err_held"}, 32'(s == 1 ? err2 : err0), 32'(eerr[s]));
   endtask

   initial begin
      bit [7:0] b8, b10;
      repeat (3) @(negedge clk);
      chk("rst moc", 32'(moc0), 32'd0);
      chk("rst busy", 32'(busy0), 32'd0);
      chk("rst err", 32'(err0), 32'd0);
      chk("rst dout", dout0, 32'd0);
      chk("rst2 busy", 32'(busy2), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) access(0, 1'b0, 2'd2, 8'(4 * i), $urandom, 0, "init");
      mem_check(0, "mem init");
      access(0, 1'b0, 2'd0, 8'd0, 32'h0000_00E2, 0, "pre0");
      access(0, 1'b0, 2'd0, 8'd1, 32'h0000_008F, 0, "pre1");
      access(0, 1'b0, 2'd0, 8'd2, 32'h0000_0010, 0, "pre2");
      access(0, 1'b0, 2'd0, 8'd3, 32'h0000_0004, 0, "pre3");
      access(0, 1'b1, 2'd2, 8'd0, 32'd0, 0, "word_read");
      chk("word_read value", dout0, 32'hE28F1004);
      b8 = model[0][8]; b10 = model[0][10];
      access(0, 1'b0, 2'd0, 8'd9, 32'hFFFF_FFAB, 0, "byte_write");
      access(0, 1'b1, 2'd0, 8'd9, 32'd0, 1, "byte_read");
      chk("byte_read value", dout0, 32'h0000_00AB);
      chk("byte8 kept", 32'(dut.r_mem[8]), 32'(b8));
      chk("byte10 kept", 32'(dut.r_mem[10]), 32'(b10));
      access(0, 1'b0, 2'd0, 8'd253, 32'h11, 0, "pw253");
      access(0, 1'b0, 2'd0, 8'd254, 32'h22, 0, "pw254");
      access(0, 1'b0, 2'd0, 8'd255, 32'h33, 0, "pw255");
      access(0, 1'b0, 2'd0, 8'd0, 32'h44, 0, "pw0");
      access(0, 1'b1, 2'd2, 8'd253, 32'd0, 3, "wrap_read");
      if (!ALIGN) chk("wrap value", dout0, 32'h1122_3344);
      access(0, 1'b0, 2'd2, 8'd2, 32'hDEAD_BEEF, 0, "word_wr_a2");
      access(0, 1'b0, 2'd1, 8'h41, 32'h1234_BEEF, 0, "half_wr_41");
      access(0, 1'b1, 2'd3, 8'h40, 32'd0, 2, "m11_read");
      mem_check(0, "mem directed");
      @(negedge clk);
      rw = 1'b0; m = 2'd2; addr = 8'd16; din = 32'hA1B2_C3D4; mov0 = 1'b1;
      model[0][16] = 8'hA1; model[0][17] = 8'hB2;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst moc", 32'(moc0), 32'd0);
      chk("midrst busy", 32'(busy0), 32'd0);
      chk("midrst err", 32'(err0), 32'd0);
      chk("midrst dout", dout0, 32'd0);
      reset = 1'b0; mov0 = 1'b0;
      edout[0] = 32'd0; edout[1] = 32'd0; eerr[0] = 1'b0; eerr[1] = 1'b0;
      mem_check(0, "mem midrst");
      for (int i = 0; i < 80; i++)
         access(0, 1'($urandom), 2'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 2)), "rand");
      mem_check(0, "mem random");
      access(1, 1'b0, 2'd2, 8'h20, 32'h0BAD_F00D, 0, "ws2 word_write");
      access(1, 1'b1, 2'd2, 8'h20, 32'd0, 3, "ws2 word_read");
      access(1, 1'b0, 2'd0, 8'h23, 32'h0000_0077, 0, "ws2 byte_write");
      access(1, 1'b1, 2'd1, 8'h22, 32'd0, 0, "ws2 half_read");
      chk("ws2 half value", dout2, 32'h0000_F077);
      mem_check(1, "mem ws2");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
